// File: rtl/vdp_pkg.sv
// vdp_pkg: shared VRAM arbiter types and default slot geometry.
package vdp_pkg;

    typedef enum logic {
        SLOT_DISP,
        SLOT_CPU
    } slot_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_WAIT,
        C_RDLAT,
        C_ACK
    } cpu_state_t;

    localparam int GROUP_DEF      = 8;
    localparam int DISP_SLOTS_DEF = 6;

endpackage

// File: rtl/vram_cpu_port.sv
// vram_cpu_port: CPU access FSM, read data register and optional posted write buffer (VRAM_WRBUF_EN).
module vram_cpu_port
    import vdp_pkg::*;
#(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          slot_free,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          issue,
    output logic          issue_we,
    output logic [AW-1:0] issue_addr,
    output logic [DW-1:0] issue_wdata
);

    cpu_state_t    state;
    logic          ack_rd;
    logic [DW-1:0] rdata_q;
    logic          buf_full;
    logic          buf_issue;
    logic          post;
    logic          cap;
    logic          fsm_issue;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_wdata;

`ifdef VRAM_WRBUF_EN
    assign post      = cpu_we && !buf_full;
    assign buf_issue = buf_full && slot_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full  <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
        end else if (cap) begin
            buf_full  <= 1'b1;
            buf_addr  <= cpu_addr;
            buf_wdata <= cpu_wdata;
        end else if (buf_issue) begin
            buf_full  <= 1'b0;
        end
    end
`else
    assign post      = 1'b0;
    assign buf_issue = 1'b0;
    assign buf_full  = 1'b0;
    assign buf_addr  = '0;
    assign buf_wdata = '0;
`endif

    // A pending buffered write drains before any new CPU access, keeping read-after-write order
    assign cap         = cpu_req && post && (state == C_IDLE || state == C_WAIT);
    assign fsm_issue   = state == C_WAIT && slot_free && !buf_full && !post;
    assign issue       = buf_issue || fsm_issue;
    assign issue_we    = buf_issue || cpu_we;
    assign issue_addr  = buf_issue ? buf_addr : cpu_addr;
    assign issue_wdata = buf_issue ? buf_wdata : cpu_wdata;
    // RAM data arrives in the ack cycle; forward it then and hold it afterwards
    assign cpu_rdata   = ack_rd ? ram_rdata : rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= C_IDLE;
            cpu_ack <= 1'b0;
            ack_rd  <= 1'b0;
            rdata_q <= '0;
        end else begin
            cpu_ack <= 1'b0;
            ack_rd  <= 1'b0;
            if (ack_rd) rdata_q <= ram_rdata;
            case (state)
                C_IDLE: begin
                    if (cap) begin
                        state   <= C_ACK;
                        cpu_ack <= 1'b1;
                    end else if (cpu_req) begin
                        state <= C_WAIT;
                    end
                end
                C_WAIT: begin
                    if (cap) begin
                        state   <= C_ACK;
                        cpu_ack <= 1'b1;
                    end else if (fsm_issue) begin
                        state   <= cpu_we ? C_ACK : C_RDLAT;
                        cpu_ack <= cpu_we;
                    end
                end
                C_RDLAT: begin
                    state   <= C_ACK;
                    cpu_ack <= 1'b1;
                    ack_rd  <= 1'b1;
                end
                default: state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: time-division VRAM arbiter between display fetch and CPU port.
// Define VRAM_WRBUF_EN to add a one-entry posted CPU write buffer.
module vram_arbiter
    import vdp_pkg::*;
#(
    parameter int AW         = 14,
    parameter int DW         = 8,
    parameter int HC_BITS    = 10,
    parameter int GROUP      = GROUP_DEF,
    parameter int DISP_SLOTS = DISP_SLOTS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [HC_BITS-1:0] col,
    input  logic               vid_active,
    input  logic               disp_req,
    input  logic [AW-1:0]      disp_addr,
    output logic               disp_gnt,
    output logic               disp_valid,
    output logic [DW-1:0]      disp_rdata,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [AW-1:0]      cpu_addr,
    input  logic [DW-1:0]      cpu_wdata,
    output logic               cpu_ack,
    output logic [DW-1:0]      cpu_rdata,
    output logic [AW-1:0]      ram_addr,
    output logic               ram_we,
    output logic [DW-1:0]      ram_wdata,
    input  logic [DW-1:0]      ram_rdata
);

    localparam logic [HC_BITS-1:0] SLOT_MASK = HC_BITS'(GROUP - 1);

    logic [HC_BITS-1:0] slot_idx;
    slot_t              slot;
    logic               slot_free;
    logic               disp_pipe;
    logic               issue;
    logic               issue_we;
    logic [AW-1:0]      issue_addr;
    logic [DW-1:0]      issue_wdata;

    assign slot_idx   = col & SLOT_MASK;
    assign slot       = (vid_active && int'(slot_idx) < DISP_SLOTS) ? SLOT_DISP : SLOT_CPU;
    // An unused display slot falls through to the CPU
    assign slot_free  = !(slot == SLOT_DISP && disp_req);
    assign disp_gnt   = !reset && slot == SLOT_DISP && disp_req;
    assign disp_rdata = ram_rdata;

    vram_cpu_port #(
        .AW(AW),
        .DW(DW)
    ) u_cpu (
        .clk        (clk),
        .reset      (reset),
        .slot_free  (slot_free),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .ram_rdata  (ram_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .issue      (issue),
        .issue_we   (issue_we),
        .issue_addr (issue_addr),
        .issue_wdata(issue_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            disp_pipe  <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            disp_pipe  <= disp_gnt;
            disp_valid <= disp_pipe;
            ram_we     <= issue && issue_we;
            if (disp_gnt) begin
                ram_addr <= disp_addr;
            end else if (issue) begin
                ram_addr  <= issue_addr;
                ram_wdata <= issue_wdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a synchronous VRAM model.
module tb_vram_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int HC = 10;
`ifdef VRAM_WRBUF_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [HC-1:0] col = '0;
    logic          vid_active = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_gnt;
    logic          disp_valid;
    logic [DW-1:0] disp_rdata;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    vram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .vid_active(vid_active),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_gnt  (disp_gnt),
        .disp_valid(disp_valid),
        .disp_rdata(disp_rdata),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        int            col;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            rd;
    } exp_t;

    exp_t disp_q[$];
    exp_t cpu_q[$];
    exp_t wr_q[$];
    int   errors = 0;
    int   checks = 0;
    logic       va = 1'b0;
    logic [7:0] mask = '0;
    logic [7:0] exp_g;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (col %0d)", name, act, exp, col);
        end
    endtask

    task automatic set_disp();
        vid_active = va;
        disp_req   = mask[col[2:0]];
        disp_addr  = AW'(14'h100 + 14'(col));
        if (va && disp_req && col[2:0] < 3'd6)
            disp_q.push_back('{int'(col) + 2, disp_addr, init_val(disp_addr), 1'b1});
    endtask

    task automatic goto(input int c);
        @(posedge clk);
        #1;
        col = HC'(c);
        if (cpu_req && cpu_ack) cpu_req = 1'b0;
        set_disp();
    endtask

    task automatic step();
        goto(int'(col) + 1);
    endtask

    task automatic flush();
        va   = 1'b0;
        mask = '0;
        repeat (4) step();
    endtask

    task automatic cpu_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int ack_col, input int we_col, input logic [DW-1:0] rd_exp);
        cpu_q.push_back('{ack_col, a, rd_exp, !we});
        if (we) wr_q.push_back('{we_col, a, d, 1'b0});
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        for (int n = 0; n < 40 && cpu_req; n++) step();
        if (cpu_req) begin
            checks++;
            errors++;
            $display("FAIL cpu_timeout: no cpu_ack for addr %0h, required by col %0d", a, ack_col);
            cpu_req = 1'b0;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (disp_valid) begin
            if (disp_q.size() == 0) chk("disp_valid_unexpected", 1, 0);
            else begin
                e = disp_q.pop_front();
                chk("disp_valid_col", int'(col), e.col);
                chk("disp_rdata", int'(disp_rdata), int'(e.data));
            end
        end
        if (cpu_ack) begin
            if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 1, 0);
            else begin
                e = cpu_q.pop_front();
                chk("cpu_ack_col", int'(col), e.col);
                if (e.rd) chk("cpu_rdata", int'(cpu_rdata), int'(e.data));
            end
        end
        if (ram_we) begin
            if (wr_q.size() == 0) chk("ram_we_unexpected", 1, 0);
            else begin
                e = wr_q.pop_front();
                chk("ram_we_col", int'(col), e.col);
                chk("ram_we_addr", int'(ram_addr), int'(e.addr));
                chk("ram_we_wdata", int'(ram_wdata), int'(e.data));
            end
        end
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = init_val(AW'(a));
        vid_active = 1'b1;
        disp_req   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_disp_gnt", int'(disp_gnt), 0);
        chk("rst_disp_valid", int'(disp_valid), 0);
        chk("rst_cpu_ack", int'(cpu_ack), 0);
        chk("rst_cpu_rdata", int'(cpu_rdata), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_ram_wdata", int'(ram_wdata), 0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        vid_active = 1'b0;
        disp_req   = 1'b0;
        repeat (2) step();

        // continuous display reads: grants in slots 0..5 only
        va    = 1'b1;
        mask  = 8'hFF;
        exp_g = 8'h3F;
        for (int c = 0; c < 8; c++) begin
            goto(c);
            @(negedge clk);
            chk("disp_gnt", int'(disp_gnt), int'(exp_g[c]));
        end
        flush();

        // CPU read in active video waits for slot 6, acks at col 8
        va   = 1'b1;
        mask = 8'hFF;
        goto(0);
        cpu_txn(1'b0, 14'h0200, 8'h00, 8, 0, init_val(14'h0200));
        flush();

        // blanking write
        goto(100);
        cpu_txn(1'b1, 14'h1234, 8'hA5, WB ? 101 : 102, 102, 8'h00);
        flush();

        // display idle in slot 2 lets the waiting CPU read through
        va   = 1'b1;
        mask = 8'hFB;
        goto(0);
        cpu_txn(1'b0, 14'h0300, 8'h00, 4, 0, init_val(14'h0300));
        flush();

        // write then read-back of the same address during active video
        va   = 1'b1;
        mask = 8'hFF;
        goto(0);
        cpu_txn(1'b1, 14'h0500, 8'h5C, WB ? 1 : 7, 7, 8'h00);
        step();
        cpu_txn(1'b0, 14'h0500, 8'h00, WB ? 9 : 16, 0, 8'h5C);
        flush();

        // reset while a read is in its latency cycle
        goto(200);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 14'h0400;
        step();
        step();
        chk("pre_reset_ram_addr", int'(ram_addr), 'h400);
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk("mid_rst_cpu_ack", int'(cpu_ack), 0);
        chk("mid_rst_cpu_rdata", int'(cpu_rdata), 0);
        chk("mid_rst_ram_addr", int'(ram_addr), 0);
        chk("mid_rst_ram_we", int'(ram_we), 0);
        chk("mid_rst_disp_valid", int'(disp_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) step();

        chk("disp_q_empty", disp_q.size(), 0);
        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
